// File: rtl/pc_sequencer.sv
// Program counter sequencer for the 9-bit CPU: next-PC selection, circular
// return-address stack and RUN/HALTED control. Every output comes from a register.
module pc_sequencer #(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 9,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             br_taken,
    input  logic [OFF_W-1:0] br_off,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [PC_W-1:0]  jmp_tgt,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic                           state;
    logic [RAS_DEPTH-1:0][PC_W-1:0] ras;
    logic [PTR_W-1:0]               tp;
    logic [PTR_W-1:0]               tp_up;
    logic [PTR_W-1:0]               tp_dn;
    logic [CNT_W-1:0]               cnt;
    logic [PC_W-1:0]                pc_inc;
    logic [PC_W-1:0]                off_ext;
    logic [PC_W-1:0]                pc_nx;
    logic                           push;
    logic                           pop;
    logic                           err_set;
    logic                           adv;

    assign pc_inc  = pc + 1'b1;
    assign off_ext = {{(PC_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign tp_up   = tp + 1'b1;
    assign tp_dn   = tp - 1'b1;
    assign adv     = en && (state == ST_RUN);

    // Priority ret > call > jmp > branch > increment; ret on an empty stack
    // degrades to an increment and flags the error.
    always_comb begin
        pc_nx   = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        err_set = 1'b0;
        if (ret) begin
            if (cnt == '0) begin
                err_set = 1'b1;
            end else begin
                pop   = 1'b1;
                pc_nx = ras[tp];
            end
        end else if (call) begin
            push    = 1'b1;
            pc_nx   = jmp_tgt;
            err_set = (cnt == CNT_MAX);
        end else if (jmp) begin
            pc_nx = jmp_tgt;
        end else if (br_taken) begin
            pc_nx = pc + off_ext;
        end
    end

    // When full, the slot above top is the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (rst_n && adv && push) begin
            ras[tp_up] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= PC_W'(RESET_PC);
            state   <= ST_RUN;
            tp      <= '0;
            cnt     <= '0;
            ras_err <= 1'b0;
        end else if (en) begin
            if (state == ST_RUN) begin
                pc      <= pc_nx;
                ras_err <= ras_err | err_set;
                if (push) begin
                    tp <= tp_up;
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                end
                if (pop) begin
                    tp  <= tp_dn;
                    cnt <= cnt - 1'b1;
                end
                if (halt_i) state <= ST_HALT;
            end else if (resume_i) begin
                state <= ST_RUN;
            end
        end
    end

    assign halted    = (state == ST_HALT);
    assign ras_empty = (cnt == '0);
    assign ras_full  = (cnt == CNT_MAX);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: a table of single-cycle operations
// with hand-computed results, plus hand-written stall/halt and reset sequences.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, en, halt_i, resume_i, br_taken, jmp, call, ret;
    logic [8:0] br_off;
    logic [9:0] jmp_tgt;
    logic [9:0] pc;
    logic       halted, ras_empty, ras_full, ras_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .halt_i(halt_i), .resume_i(resume_i),
        .br_taken(br_taken), .br_off(br_off), .jmp(jmp), .call(call), .ret(ret),
        .jmp_tgt(jmp_tgt), .pc(pc), .halted(halted), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    typedef enum logic [3:0] {
        OP_NOP, OP_BR, OP_JMP, OP_CALL, OP_RET, OP_BRJ, OP_CR, OP_HALT,
        OP_HALTJ, OP_RES, OP_STALL, OP_HOLDALL, OP_RST, OP_RST0
    } op_t;

    typedef struct {
        op_t        op;
        logic [9:0] arg;
        logic [9:0] e_pc;
        logic       e_h, e_e, e_f, e_r;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input op_t op, input logic [9:0] arg, input logic [9:0] e_pc,
                               input logic e_h, input logic e_e, input logic e_f, input logic e_r);
        vec_t t;
        t.op = op; t.arg = arg; t.e_pc = e_pc;
        t.e_h = e_h; t.e_e = e_e; t.e_f = e_f; t.e_r = e_r;
        return t;
    endfunction

    task automatic drive(input op_t op, input logic [9:0] arg);
        rst_n = 1'b1; en = 1'b1; halt_i = 1'b0; resume_i = 1'b0;
        br_taken = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        br_off = arg[8:0]; jmp_tgt = arg;
        case (op)
            OP_BR:      br_taken = 1'b1;
            OP_JMP:     jmp = 1'b1;
            OP_CALL:    call = 1'b1;
            OP_RET:     ret = 1'b1;
            OP_BRJ:     begin br_taken = 1'b1; jmp = 1'b1; end
            OP_CR:      begin call = 1'b1; ret = 1'b1; end
            OP_HALT:    halt_i = 1'b1;
            OP_HALTJ:   begin halt_i = 1'b1; jmp = 1'b1; end
            OP_RES:     resume_i = 1'b1;
            OP_STALL:   begin en = 1'b0; call = 1'b1; ret = 1'b1; jmp = 1'b1;
                              br_taken = 1'b1; halt_i = 1'b1; end
            OP_HOLDALL: begin call = 1'b1; ret = 1'b1; jmp = 1'b1;
                              br_taken = 1'b1; halt_i = 1'b1; end
            OP_RST:     rst_n = 1'b0;
            OP_RST0:    begin rst_n = 1'b0; en = 1'b0; jmp = 1'b1; end
            default:    ;
        endcase
    endtask

    task automatic apply(input string name, input vec_t t);
        @(negedge clk);
        drive(t.op, t.arg);
        @(posedge clk);
        #1;
        checks++;
        if ({pc, halted, ras_empty, ras_full, ras_err} !== {t.e_pc, t.e_h, t.e_e, t.e_f, t.e_r}) begin
            errors++;
            $display("FAIL %s op=%0d: got pc=%0d h=%b e=%b f=%b err=%b, want pc=%0d h=%b e=%b f=%b err=%b",
                     name, t.op, pc, halted, ras_empty, ras_full, ras_err,
                     t.e_pc, t.e_h, t.e_e, t.e_f, t.e_r);
        end
    endtask

    initial begin
        drive(OP_RST, 10'd0);

        // reset, increment, wrap
        tbl.push_back(v(OP_RST,  10'd0,    10'd0,    0, 1, 0, 0));
        for (int i = 1; i <= 5; i++) tbl.push_back(v(OP_NOP, 10'd0, 10'(i), 0, 1, 0, 0));
        tbl.push_back(v(OP_JMP,  10'd1022, 10'd1022, 0, 1, 0, 0));
        tbl.push_back(v(OP_NOP,  10'd0,    10'd1023, 0, 1, 0, 0));
        tbl.push_back(v(OP_NOP,  10'd0,    10'd0,    0, 1, 0, 0));
        tbl.push_back(v(OP_NOP,  10'd0,    10'd1,    0, 1, 0, 0));
        // branches and priority
        tbl.push_back(v(OP_JMP,  10'd10,   10'd10,   0, 1, 0, 0));
        tbl.push_back(v(OP_BR,   10'h1FD,  10'd7,    0, 1, 0, 0));
        tbl.push_back(v(OP_JMP,  10'd1,    10'd1,    0, 1, 0, 0));
        tbl.push_back(v(OP_BR,   10'h1FD,  10'd1022, 0, 1, 0, 0));
        tbl.push_back(v(OP_BR,   10'd100,  10'd98,   0, 1, 0, 0));
        tbl.push_back(v(OP_BRJ,  10'd100,  10'd100,  0, 1, 0, 0));
        // call/ret, overflow, underflow
        tbl.push_back(v(OP_JMP,  10'd20,   10'd20,   0, 1, 0, 0));
        tbl.push_back(v(OP_CALL, 10'd200,  10'd200,  0, 0, 0, 0));
        tbl.push_back(v(OP_RET,  10'd0,    10'd21,   0, 1, 0, 0));
        tbl.push_back(v(OP_JMP,  10'd0,    10'd0,    0, 1, 0, 0));
        tbl.push_back(v(OP_CALL, 10'd50,   10'd50,   0, 0, 0, 0));
        tbl.push_back(v(OP_CALL, 10'd60,   10'd60,   0, 0, 0, 0));
        tbl.push_back(v(OP_CALL, 10'd70,   10'd70,   0, 0, 0, 0));
        tbl.push_back(v(OP_CALL, 10'd80,   10'd80,   0, 0, 1, 0));
        tbl.push_back(v(OP_CALL, 10'd300,  10'd300,  0, 0, 1, 1));
        tbl.push_back(v(OP_RET,  10'd0,    10'd81,   0, 0, 0, 1));
        tbl.push_back(v(OP_RET,  10'd0,    10'd71,   0, 0, 0, 1));
        tbl.push_back(v(OP_RET,  10'd0,    10'd61,   0, 0, 0, 1));
        tbl.push_back(v(OP_RET,  10'd0,    10'd51,   0, 1, 0, 1));
        tbl.push_back(v(OP_RET,  10'd0,    10'd52,   0, 1, 0, 1));
        // ret beats call: empty ret increments without pushing; non-empty ret pops
        tbl.push_back(v(OP_CR,   10'd400,  10'd53,   0, 1, 0, 1));
        tbl.push_back(v(OP_CALL, 10'd500,  10'd500,  0, 0, 0, 1));
        tbl.push_back(v(OP_CR,   10'd400,  10'd54,   0, 1, 0, 1));
        tbl.push_back(v(OP_RST,  10'd0,    10'd0,    0, 1, 0, 0));

        foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

        // stall, halt with hold, resume
        apply("call3",  v(OP_CALL, 10'd3, 10'd3, 0, 0, 0, 0));
        apply("inc4",   v(OP_NOP,  10'd0, 10'd4, 0, 0, 0, 0));
        apply("inc5",   v(OP_NOP,  10'd0, 10'd5, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            apply($sformatf("stall%0d", i), v(OP_STALL, 10'd700, 10'd5, 0, 0, 0, 0));
        apply("halt",   v(OP_HALT, 10'd0, 10'd6, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            apply($sformatf("hold%0d", i), v(OP_HOLDALL, 10'd700, 10'd6, 1, 0, 0, 0));
        apply("resume", v(OP_RES,  10'd0, 10'd6, 0, 0, 0, 0));
        apply("run7",   v(OP_NOP,  10'd0, 10'd7, 0, 0, 0, 0));
        apply("ret1",   v(OP_RET,  10'd0, 10'd1, 0, 1, 0, 0));

        // reset while halted with a full stack and sticky error
        apply("rst_a",  v(OP_RST,  10'd0, 10'd0, 0, 1, 0, 0));
        for (int i = 1; i <= 4; i++)
            apply($sformatf("fill%0d", i), v(OP_CALL, 10'(10 * i), 10'(10 * i), 0, 0, i == 4, 0));
        apply("ovf",    v(OP_CALL,  10'd50, 10'd50, 0, 0, 1, 1));
        apply("haltj",  v(OP_HALTJ, 10'd77, 10'd77, 1, 0, 1, 1));
        apply("rst_h",  v(OP_RST,   10'd0,  10'd0,  0, 1, 0, 0));
        apply("jmp9",   v(OP_JMP,   10'd9,  10'd9,  0, 1, 0, 0));
        apply("call100",v(OP_CALL,  10'd100,10'd100,0, 0, 0, 0));
        apply("rst_en0",v(OP_RST0,  10'd5,  10'd0,  0, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
